// File: rtl/quad_step_decoder_pkg.sv
// Shared types for the quadrature step decoder: {A,B} state encoding, step
// direction codes and the transition-to-direction helper.
package quad_pkg;

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S11 = 2'b11,
    S10 = 2'b10
  } quad_state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_e;

  // Forward order is 00 -> 01 -> 11 -> 10 -> 00; anything else is a hold or an illegal jump.
  function automatic dir_e step_dir(input quad_state_e cur, input logic [1:0] nxt);
    logic [1:0] fwd;
    logic [1:0] rev;
    fwd = 2'b00;
    rev = 2'b00;
    unique case (cur)
      S00: begin fwd = 2'b01; rev = 2'b10; end
      S01: begin fwd = 2'b11; rev = 2'b00; end
      S11: begin fwd = 2'b10; rev = 2'b01; end
      S10: begin fwd = 2'b00; rev = 2'b11; end
      default: begin fwd = 2'b00; rev = 2'b00; end
    endcase
    if (nxt == fwd) begin
      step_dir = DIR_UP;
    end else if (nxt == rev) begin
      step_dir = DIR_DN;
    end else begin
      step_dir = DIR_NONE;
    end
  endfunction

  function automatic logic is_illegal(input quad_state_e cur, input logic [1:0] nxt);
    is_illegal = ((cur ^ nxt) == 2'b11);
  endfunction

endpackage

// File: rtl/quad_step_decoder_if.sv
// Encoder/button inputs and counter-facing strobes of the quadrature step decoder.
interface quad_step_decoder_if;

  logic       enc_a;
  logic       enc_b;
  logic       preset_btn;
  logic [3:0] preset_val;
  logic       up;
  logic       down;
  logic       load;
  logic [3:0] data_out;
  logic       err;

  modport master (
    output enc_a, enc_b, preset_btn, preset_val,
    input  up, down, load, data_out, err
  );

  modport slave (
    input  enc_a, enc_b, preset_btn, preset_val,
    output up, down, load, data_out, err
  );

endinterface

// File: rtl/quad_step_decoder_debounce_sync.sv
// Two-flop synchroniser followed by a hold-time debouncer; while not primed the
// stable level follows the synchronised input directly.
module debounce_sync #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned DB_W            = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic primed,
  input  logic raw,
  output logic stable
);

  localparam logic [DB_W-1:0] CntMax = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            s1_q, s2_q;
  logic            stable_q, stable_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (!primed) begin
      stable_d = s2_q;
    end else if (s2_q != stable_q) begin
      if (cnt_q == CntMax) begin
        stable_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature x4 decoder with preset-button load strobe; steps that collide
// with a load are deferred one cycle through a single pending slot.
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned DB_W            = 8
) (
  input logic                clk,
  input logic                rst,
  quad_step_decoder_if.slave bus
);

  logic stable_a, stable_b, stable_btn;

  logic [1:0]  prime_cnt_q;
  logic        primed_q;
  logic        dec_en_q;

  quad_state_e state_q;
  dir_e        pend_q, pend_d;
  dir_e        step, issue;
  logic        btn_q;
  logic        load_evt;
  logic        illegal;
  logic [1:0]  enc_now;

  logic        up_q, down_q, load_q, err_q;
  logic [3:0]  data_q;

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_a (
    .clk    (clk),
    .rst    (rst),
    .primed (primed_q),
    .raw    (bus.enc_a),
    .stable (stable_a)
  );

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_b (
    .clk    (clk),
    .rst    (rst),
    .primed (primed_q),
    .raw    (bus.enc_b),
    .stable (stable_b)
  );

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_btn (
    .clk    (clk),
    .rst    (rst),
    .primed (primed_q),
    .raw    (bus.preset_btn),
    .stable (stable_btn)
  );

  // Decoding waits one cycle past priming so the FSM has caught up with the
  // bypassed levels and never sees the priming fill as a transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      prime_cnt_q <= 2'd0;
      primed_q    <= 1'b0;
      dec_en_q    <= 1'b0;
    end else begin
      if (!primed_q) begin
        if (prime_cnt_q == 2'd2) begin
          primed_q <= 1'b1;
        end else begin
          prime_cnt_q <= prime_cnt_q + 2'd1;
        end
      end
      dec_en_q <= primed_q;
    end
  end

  assign enc_now  = {stable_a, stable_b};
  assign illegal  = is_illegal(state_q, enc_now);
  assign step     = step_dir(state_q, enc_now);
  assign load_evt = stable_btn & ~btn_q;

  // Arbitration between a fresh step, the pending slot and a load strobe.
  always_comb begin
    pend_d = pend_q;
    issue  = DIR_NONE;
    if (load_evt) begin
      if (pend_q == DIR_NONE) begin
        pend_d = step;
      end else if (step != DIR_NONE && step != pend_q) begin
        pend_d = DIR_NONE;
      end
    end else if (pend_q == DIR_NONE) begin
      issue = step;
    end else if (step == DIR_NONE) begin
      issue  = pend_q;
      pend_d = DIR_NONE;
    end else if (step == pend_q) begin
      issue  = pend_q;
      pend_d = step;
    end else begin
      pend_d = DIR_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S00;
      btn_q   <= 1'b0;
      pend_q  <= DIR_NONE;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= 4'd0;
    end else begin
      state_q <= quad_state_e'(enc_now);
      btn_q   <= stable_btn;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      if (dec_en_q) begin
        pend_q <= pend_d;
        up_q   <= (issue == DIR_UP);
        down_q <= (issue == DIR_DN);
        err_q  <= illegal;
        if (load_evt) begin
          load_q <= 1'b1;
          data_q <= bus.preset_val;
        end
      end
    end
  end

  assign bus.up       = up_q;
  assign bus.down     = down_q;
  assign bus.load     = load_q;
  assign bus.err      = err_q;
  assign bus.data_out = data_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder with a model of the downstream 4-bit counter.
module tb_quad_step_decoder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  quad_step_decoder_if bus ();

  quad_step_decoder #(.DEBOUNCE_CYCLES(4), .DB_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int viol   = 0;

  logic [3:0]  cnt_m;
  logic [31:0] up_m, dn_m, ld_m, er_m, g;

  // Attached loadable up/down counter.
  always @(posedge clk) begin
    if (rst) cnt_m <= 4'd0;
    else if (bus.load) cnt_m <= bus.data_out;
    else if (bus.up) cnt_m <= cnt_m + 4'd1;
    else if (bus.down) cnt_m <= cnt_m - 4'd1;
  end

  always @(negedge clk) begin
    if (!rst && ((bus.up && bus.down) || ((bus.up || bus.down) && bus.load))) viol++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_window(input int n);
    up_m = '0; dn_m = '0; ld_m = '0; er_m = '0;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (bus.up) up_m[k] = 1'b1;
      if (bus.down) dn_m[k] = 1'b1;
      if (bus.load) ld_m[k] = 1'b1;
      if (bus.err) er_m[k] = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_win(input string tag, input logic [31:0] up_e, input logic [31:0] dn_e,
                         input logic [31:0] ld_e, input logic [31:0] er_e);
    chk({tag, ".up"}, up_m, up_e);
    chk({tag, ".down"}, dn_m, dn_e);
    chk({tag, ".load"}, ld_m, ld_e);
    chk({tag, ".err"}, er_m, er_e);
  endtask

  task automatic step(input logic a, input logic b, input string tag,
                      input logic [31:0] up_e, input logic [31:0] dn_e);
    bus.enc_a = a;
    bus.enc_b = b;
    run_window(10);
    chk_win(tag, up_e, dn_e, 32'd0, 32'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".up"}, {31'd0, bus.up}, 32'd0);
    chk({tag, ".down"}, {31'd0, bus.down}, 32'd0);
    chk({tag, ".load"}, {31'd0, bus.load}, 32'd0);
    chk({tag, ".err"}, {31'd0, bus.err}, 32'd0);
    chk({tag, ".data"}, {28'd0, bus.data_out}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.enc_a = 1'b0;
    bus.enc_b = 1'b0;
    bus.preset_btn = 1'b0;
    bus.preset_val = 4'd0;
    repeat (3) tick();
    chk_idle("reset");

    rst = 1'b0;
    run_window(8);
    chk_win("prime", 32'd0, 32'd0, 32'd0, 32'd0);

    // Forward: each strobe lands on the 7th sampled edge of its window.
    step(1'b0, 1'b1, "fwd01", 32'd1 << 7, 32'd0);
    step(1'b1, 1'b1, "fwd11", 32'd1 << 7, 32'd0);
    step(1'b1, 1'b0, "fwd10", 32'd1 << 7, 32'd0);
    step(1'b0, 1'b0, "fwd00", 32'd1 << 7, 32'd0);
    chk("cnt_fwd", {28'd0, cnt_m}, 32'd4);

    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    run_window(8);
    chk("cnt_rst", {28'd0, cnt_m}, 32'd0);

    step(1'b1, 1'b0, "rev10", 32'd0, 32'd1 << 7);
    step(1'b1, 1'b1, "rev11", 32'd0, 32'd1 << 7);
    step(1'b0, 1'b1, "rev01", 32'd0, 32'd1 << 7);
    step(1'b0, 1'b0, "rev00", 32'd0, 32'd1 << 7);
    chk("cnt_wrap", {28'd0, cnt_m}, 32'd12);

    bus.enc_a = 1'b1;
    run_window(2);
    g = up_m | dn_m | ld_m | er_m;
    bus.enc_a = 1'b0;
    run_window(12);
    chk("glitch2", g | up_m | dn_m | ld_m | er_m, 32'd0);

    bus.enc_a = 1'b1;
    run_window(3);
    g = up_m | dn_m | ld_m | er_m;
    bus.enc_a = 1'b0;
    run_window(12);
    chk("glitch3", g | up_m | dn_m | ld_m | er_m, 32'd0);

    bus.enc_a = 1'b1;
    bus.enc_b = 1'b1;
    run_window(10);
    chk_win("illegal", 32'd0, 32'd0, 32'd0, 32'd1 << 7);
    step(1'b1, 1'b0, "after_err", 32'd1 << 7, 32'd0);
    chk("cnt_after_err", {28'd0, cnt_m}, 32'd13);

    bus.preset_val = 4'd13;
    bus.preset_btn = 1'b1;
    run_window(20);
    chk_win("press", 32'd0, 32'd0, 32'd1 << 7, 32'd0);
    chk("data_press", {28'd0, bus.data_out}, 32'd13);
    chk("cnt_load", {28'd0, cnt_m}, 32'd13);
    bus.preset_btn = 1'b0;
    run_window(20);
    chk_win("release", 32'd0, 32'd0, 32'd0, 32'd0);
    chk("data_hold", {28'd0, bus.data_out}, 32'd13);

    // Step and press on the same edge: load first, step one cycle later.
    bus.preset_btn = 1'b1;
    bus.enc_a = 1'b0;
    bus.enc_b = 1'b0;
    run_window(12);
    chk_win("collide", 32'd1 << 8, 32'd0, 32'd1 << 7, 32'd0);
    chk("cnt_collide", {28'd0, cnt_m}, 32'd14);
    bus.preset_btn = 1'b0;
    run_window(12);

    // Deferred step meets a same-direction step on the following cycle.
    bus.preset_btn = 1'b1;
    bus.enc_b = 1'b1;
    tick();
    bus.enc_a = 1'b1;
    run_window(11);
    chk_win("pend_same", (32'd1 << 7) | (32'd1 << 8), 32'd0, 32'd1 << 6, 32'd0);
    chk("cnt_pend", {28'd0, cnt_m}, 32'd15);
    bus.preset_btn = 1'b0;
    run_window(12);

    bus.enc_a = 1'b1;
    bus.enc_b = 1'b0;
    run_window(3);
    rst = 1'b1;
    tick();
    chk_idle("mid_rst");
    tick();
    rst = 1'b0;
    run_window(20);
    chk_win("abort", 32'd0, 32'd0, 32'd0, 32'd0);

    chk("exclusive", viol, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
